fpu_share_sched: RTL and testbench
==================================

Name: fpu_share_sched

Overview:
- Shares one fixed-latency FPU datapath (operands iA/iB, 2-bit opcode, 32-bit result) between NREQ requesters, e.g. several mailbox front-ends like the QSPI RAM adapter.
- Round-robin arbitration with at most one issue per clock.
- Tracks each in-flight operation by requester ID through the FPU pipeline and routes each result back to the requester that issued it.
- Each requester may have at most one operation outstanding.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 4, FPU latency in clocks from operand/opcode register update to a valid fpu_result (1..16).
- ID_W, 2, requester ID width; must equal ceil(log2(NREQ)).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  32*NREQ  operand A; requester i uses bits [32i+31:32i].
- req_b  in  32*NREQ  operand B, packed as req_a.
- req_op  in  2*NREQ  opcode; requester i uses bits [2i+1:2i].
- req_ready  out  NREQ  grant, one-hot or zero; handshake completes when valid & ready.
- fpu_a  out  32  registered operand A to the FPU.
- fpu_b  out  32  registered operand B to the FPU.
- fpu_op  out  2  registered opcode to the FPU.
- fpu_result  in  32  FPU result.
- rsp_valid  out  NREQ  one-hot, single-cycle result strobe.
- rsp_id  out  ID_W  ID of the requester receiving the result.
- rsp_result  out  32  registered result.
- busy  out  1  high while any operation is in flight.

Behaviour:
- Reset (asynchronous, mid-operation included): req_ready=0, fpu_a/b=0, fpu_op=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, RR pointer=0.
  - The tag pipeline and outstanding flags clear; in-flight operations are dropped with no response.
- Eligibility: requester i is eligible when req_valid[i]=1 and outstanding[i]=0.
- Arbitration is combinational:
  - Search eligible requesters starting at the RR pointer, ascending with wrap from NREQ-1 to 0.
  - The first eligible requester gets req_ready.
  - req_ready is never high for a non-eligible requester.
- Issue edge (any req_valid&req_ready):
  - fpu_a/b/op <= the granted requester's fields.
  - outstanding[g] <= 1.
  - RR pointer <= (g+1) mod NREQ.
  - A tag {1, g} enters the tag shift register (depth LAT+1, one stage per clock).
- No grant: the RR pointer and fpu_* hold their values; an invalid tag {0, x} is shifted in.
- Tag exit: LAT+1 clocks after the issue edge, on the edge where the valid tag leaves the shift register:
  - rsp_result <= fpu_result.
  - rsp_id <= g.
  - rsp_valid[g] <= 1 for exactly one cycle.
  - outstanding[g] <= 0.
- Latency: issue edge to rsp_valid high is LAT+1 clocks. Throughput is one op per clock across distinct requesters.
- Re-grant timing: requester g can be granted again no earlier than the cycle in which rsp_valid[g] is high.
  - Same edge: a response clearing outstanding[g] and a new grant to g cannot coincide; the clear wins and the grant occurs at least one cycle later.
- Otherwise rsp_valid=0. rsp_result and rsp_id hold their last value.
- busy = OR of the outstanding flags.
- Requests are sampled only at handshake. req_valid deasserted before grant is legal (no issue). The bench must not check operand stability.
- Opcode is passed through unmodified; the datapath defines its meaning (2'b00 = add).

Optional Feature:
- Macro FPU_SHARE_SCHED_PRIO0_EN.
- Defined: requester 0, when eligible, is always granted, regardless of the RR pointer. The RR pointer updates only on grants to requesters 1..NREQ-1, and RR search over 1..NREQ-1 is unchanged.
- Undefined: pure round-robin over all requesters as above.

Test Plan:
- Single op: after reset, req0 a=0x3F800000, b=0x40000000, op=00 → req_ready[0] same cycle; fpu_a/b updated next edge; FPU model returns 0x40400000; rsp_valid[0] pulse LAT+1 clocks after the issue edge, rsp_id=0, rsp_result=0x40400000, busy low the following cycle.
- Round-robin: all four requesters hold valid from reset → grants in order 0,1,2,3 on consecutive cycles; responses in the same order, one per cycle. Requester 0 is re-granted only after its rsp_valid.
- Pointer wrap: pointer=3, requesters 0 and 2 valid → grant 0 first, then 2. Regranting is blocked until the outstanding flags clear.
- Outstanding block: req1 valid continuously → exactly one grant per LAT+2 cycles; no second grant before rsp_valid[1].
- Reset mid-flight: assert rst_n=0 two cycles after an issue → all outputs 0 immediately; no rsp_valid after release; the first grant after release goes to the lowest eligible ID.
- With FPU_SHARE_SCHED_PRIO0_EN defined: req0 and req2 valid, RR pointer=2 → req0 granted first, then req2; the pointer is unchanged by the req0 grant.

Source files
------------

// File: rtl/fpu_share_sched_if.sv
// rtl/fpu_share_sched_if.sv - requester-side request/response bundle for the shared FPU scheduler
interface fpu_share_sched_if #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [2*NREQ-1:0]  req_op;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [ID_W-1:0]    rsp_id;
    logic [31:0]        rsp_result;

    // Requester side: drives operands, receives grants and results.
    modport master (
        output req_valid, req_a, req_b, req_op,
        input  req_ready, rsp_valid, rsp_id, rsp_result
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b, req_op,
        output req_ready, rsp_valid, rsp_id, rsp_result
    );
endinterface

// File: rtl/fpu_share_sched.sv
// rtl/fpu_share_sched.sv - round-robin sharing of one fixed-latency FPU among NREQ requesters (optional FPU_SHARE_SCHED_PRIO0_EN: requester 0 always wins)
module fpu_share_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 4,
    parameter int ID_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fpu_share_sched_if.slave     bus,
    output logic [31:0]          fpu_a,
    output logic [31:0]          fpu_b,
    output logic [1:0]           fpu_op,
    input  logic [31:0]          fpu_result,
    output logic                 busy
);

    logic [NREQ-1:0] outstanding;
    logic [NREQ-1:0] eligible;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_id;
    logic            grant_any;

    // Tag pipeline: one {valid, id} per clock, LAT+1 stages deep so the tag
    // leaves exactly when the FPU result for that issue is present.
    logic [LAT:0]    tag_v;
    logic [ID_W-1:0] tag_id [0:LAT];
    logic            exit_v;
    logic [ID_W-1:0] exit_id;

    assign eligible = bus.req_valid & ~outstanding;
    assign exit_v   = tag_v[LAT];
    assign exit_id  = tag_id[LAT];
    assign busy     = |outstanding;

    // Pick the first eligible requester from the RR pointer upward, with wrap.
    always_comb begin
        logic [ID_W-1:0] cand;
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
`ifdef FPU_SHARE_SCHED_PRIO0_EN
        if (eligible[0]) begin
            grant_any = 1'b1;
            grant_id  = '0;
        end
`endif
        for (int k = 0; k < NREQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NREQ);
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
    end

    // Grant is forced low while reset is held so nothing looks accepted.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && grant_any) begin
            bus.req_ready = NREQ'(1) << grant_id;
        end
    end

    // Issue: capture the winner's operands and advance the RR pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpu_a  <= '0;
            fpu_b  <= '0;
            fpu_op <= '0;
            rr_ptr <= '0;
        end else if (grant_any) begin
            fpu_a  <= bus.req_a[32*grant_id +: 32];
            fpu_b  <= bus.req_b[32*grant_id +: 32];
            fpu_op <= bus.req_op[2*grant_id +: 2];
`ifdef FPU_SHARE_SCHED_PRIO0_EN
            if (grant_id != '0) begin
                rr_ptr <= (grant_id == ID_W'(NREQ-1)) ? '0 : grant_id + 1'b1;
            end
`else
            rr_ptr <= (grant_id == ID_W'(NREQ-1)) ? '0 : grant_id + 1'b1;
`endif
        end
    end

    // Shift the issue tag along in lockstep with the FPU pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            for (int s = 0; s <= LAT; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_v     <= {tag_v[LAT-1:0], grant_any};
            tag_id[0] <= grant_id;
            for (int s = 1; s <= LAT; s++) begin
                tag_id[s] <= tag_id[s-1];
            end
        end
    end

    // Outstanding flags: set on issue, cleared when the tag exits. A set and a
    // clear never hit the same requester on one edge, since a grant needs the
    // flag already clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (exit_v && exit_id == ID_W'(i)) begin
                    outstanding[i] <= 1'b0;
                end else if (grant_any && grant_id == ID_W'(i)) begin
                    outstanding[i] <= 1'b1;
                end
            end
        end
    end

    // Route the result to its owner; id and result hold between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid  <= '0;
            bus.rsp_id     <= '0;
            bus.rsp_result <= '0;
        end else if (exit_v) begin
            bus.rsp_valid  <= NREQ'(1) << exit_id;
            bus.rsp_id     <= exit_id;
            bus.rsp_result <= fpu_result;
        end else begin
            bus.rsp_valid  <= '0;
        end
    end

endmodule

// File: tb/tb_fpu_share_sched.sv
// tb/tb_fpu_share_sched.sv - directed self-checking bench for fpu_share_sched
module tb_fpu_share_sched;
    localparam int NREQ = 4;
    localparam int LAT  = 4;
    localparam int ID_W = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [1:0]  fpu_op;
    logic [31:0] fpu_result;
    logic        busy;
    logic [31:0] fpu_pipe [0:LAT-1];

    int checks = 0;
    int errors = 0;

    fpu_share_sched_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

    fpu_share_sched #(.NREQ(NREQ), .LAT(LAT), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .fpu_a      (fpu_a),
        .fpu_b      (fpu_b),
        .fpu_op     (fpu_op),
        .fpu_result (fpu_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in FPU datapath: exact for 1.0+2.0, a scrambling function otherwise.
    function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
        if (op == 2'b00 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
    endfunction

    // Fixed LAT-clock FPU pipeline fed from the registered operands.
    always @(posedge clk) begin
        fpu_pipe[0] <= fpu_fn(fpu_a, fpu_b, fpu_op);
        for (int s = 1; s < LAT; s++) fpu_pipe[s] <= fpu_pipe[s-1];
    end
    assign fpu_result = fpu_pipe[LAT-1];

    function automatic logic [31:0] vec_a(input int i);
        return 32'hA5A5_0000 | i;
    endfunction
    function automatic logic [31:0] vec_b(input int i);
        return 32'h0F0F_0100 + (i << 4);
    endfunction
    function automatic logic [1:0] vec_op(input int i);
        return 2'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op);
        bus.req_valid[i]      = 1'b1;
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
        bus.req_op[2*i +: 2]  = op;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: busy=%b after %0d cycles, required 0", name, busy, n);
        end
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.req_valid = '1;
        rst_n = 1'b0;
        #3;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b required 0000", bus.req_ready); end
        checks++; if (fpu_a !== 32'd0 || fpu_b !== 32'd0 || fpu_op !== 2'd0) begin errors++; $display("FAIL reset_fpu: got %h %h %b required zeros", fpu_a, fpu_b, fpu_op); end
        checks++; if (bus.rsp_valid !== 4'b0000 || bus.rsp_id !== 2'd0 || bus.rsp_result !== 32'd0) begin errors++; $display("FAIL reset_rsp: got %b %0d %h required zeros", bus.rsp_valid, bus.rsp_id, bus.rsp_result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        tick();
        tick();
        checks++; if (bus.req_ready !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL reset_held: ready=%b busy=%b required 0000/0", bus.req_ready, busy); end
        clear_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_op();
        int n = 0;
        do_reset();
        set_req(0, 32'h3F80_0000, 32'h4000_0000, 2'b00);
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b required 0001", bus.req_ready); end
        tick();
        clear_inputs();
        checks++; if (fpu_a !== 32'h3F80_0000 || fpu_b !== 32'h4000_0000 || fpu_op !== 2'b00) begin errors++; $display("FAIL single_fpu_regs: got %h %h %b required 3f800000 40000000 00", fpu_a, fpu_b, fpu_op); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_hi: got %b required 1", busy); end
        while (bus.rsp_valid === 4'b0000 && n < 20) begin
            tick();
            n++;
        end
        checks++; if (n != LAT + 1) begin errors++; $display("FAIL single_latency: got %0d required %0d", n, LAT + 1); end
        checks++; if (bus.rsp_valid !== 4'b0001 || bus.rsp_id !== 2'd0) begin errors++; $display("FAIL single_rsp: got valid=%b id=%0d required 0001/0", bus.rsp_valid, bus.rsp_id); end
        checks++; if (bus.rsp_result !== 32'h4040_0000) begin errors++; $display("FAIL single_result: got %h required 40400000", bus.rsp_result); end
        tick();
        checks++; if (bus.rsp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_after: got valid=%b busy=%b required 0000/0", bus.rsp_valid, busy); end
        checks++; if (bus.rsp_result !== 32'h4040_0000) begin errors++; $display("FAIL single_hold: got %h required 40400000", bus.rsp_result); end
    endtask

    task automatic test_round_robin();
        int n = 0;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, vec_a(i), vec_b(i), vec_op(i));
        #1;
        for (int k = 0; k < NREQ; k++) begin
            checks++; if (bus.req_ready !== 4'(1 << k)) begin errors++; $display("FAIL rr_grant%0d: got %b required %b", k, bus.req_ready, 4'(1 << k)); end
            tick();
        end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rr_blocked: got %b required 0000", bus.req_ready); end
        while (bus.rsp_valid === 4'b0000 && n < 20) begin
            checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rr_early_regrant: got %b required 0000", bus.req_ready); end
            tick();
            n++;
        end
        for (int k = 0; k < NREQ; k++) begin
            checks++; if (bus.rsp_valid !== 4'(1 << k) || bus.rsp_id !== 2'(k)) begin errors++; $display("FAIL rr_rsp%0d: got valid=%b id=%0d required %b/%0d", k, bus.rsp_valid, bus.rsp_id, 4'(1 << k), k); end
            checks++; if (bus.rsp_result !== fpu_fn(vec_a(k), vec_b(k), vec_op(k))) begin errors++; $display("FAIL rr_result%0d: got %h required %h", k, bus.rsp_result, fpu_fn(vec_a(k), vec_b(k), vec_op(k))); end
            checks++; if (bus.req_ready !== 4'(1 << k)) begin errors++; $display("FAIL rr_regrant%0d: got %b required %b", k, bus.req_ready, 4'(1 << k)); end
            tick();
        end
        clear_inputs();
        drain("rr");
    endtask

    task automatic test_pointer_wrap();
        do_reset();
        set_req(2, vec_a(2), vec_b(2), vec_op(2));
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_setup: got %b required 0100", bus.req_ready); end
        tick();
        clear_inputs();
        drain("wrap_setup");
        set_req(0, vec_a(0), vec_b(0), vec_op(0));
        set_req(2, vec_a(2), vec_b(2), vec_op(2));
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_first: got %b required 0001", bus.req_ready); end
        tick();
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_second: got %b required 0100", bus.req_ready); end
        tick();
        for (int c = 0; c < 3; c++) begin
            checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL wrap_blocked%0d: got %b required 0000", c, bus.req_ready); end
            tick();
        end
        clear_inputs();
        drain("wrap");
    endtask

    task automatic test_outstanding_block();
        int grants = 0;
        do_reset();
        set_req(1, vec_a(1), vec_b(1), vec_op(1));
        #1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            checks++; if ((bus.req_ready & 4'b1101) !== 4'b0000) begin errors++; $display("FAIL block_other_ready: cycle %0d got %b required only bit1", cyc, bus.req_ready); end
            if (bus.req_ready[1] === 1'b1) begin
                checks++; if (cyc != grants * (LAT + 2)) begin errors++; $display("FAIL block_grant_cycle: got %0d required %0d", cyc, grants * (LAT + 2)); end
                if (grants > 0) begin
                    checks++; if (bus.rsp_valid !== 4'b0010) begin errors++; $display("FAIL block_regrant_rsp: got %b required 0010", bus.rsp_valid); end
                end
                grants++;
            end
            tick();
        end
        checks++; if (grants != 4) begin errors++; $display("FAIL block_grant_count: got %0d required 4", grants); end
        clear_inputs();
        drain("block");
    endtask

    task automatic test_reset_midflight();
        logic seen = 1'b0;
        set_req(1, vec_a(1), vec_b(1), vec_op(1));
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL mid_grant: got %b required 0010", bus.req_ready); end
        tick();
        clear_inputs();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (fpu_a !== 32'd0 || fpu_b !== 32'd0 || fpu_op !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_fpu: got %h %h %b busy=%b required zeros", fpu_a, fpu_b, fpu_op, busy); end
        checks++; if (bus.rsp_valid !== 4'b0000 || bus.rsp_id !== 2'd0 || bus.rsp_result !== 32'd0 || bus.req_ready !== 4'b0000) begin errors++; $display("FAIL mid_reset_rsp: got %b %0d %h ready=%b required zeros", bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.req_ready); end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.rsp_valid !== 4'b0000) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_rsp: got rsp_valid after release, required none"); end
        set_req(2, vec_a(2), vec_b(2), vec_op(2));
        set_req(3, vec_a(3), vec_b(3), vec_op(3));
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL mid_first_grant: got %b required 0100", bus.req_ready); end
        tick();
        clear_inputs();
        drain("mid");
    endtask

    task automatic test_prio();
        logic [3:0] exp_first;
        logic [3:0] exp_second;
`ifdef FPU_SHARE_SCHED_PRIO0_EN
        exp_first  = 4'b0001;
        exp_second = 4'b0100;
`else
        exp_first  = 4'b0100;
        exp_second = 4'b0001;
`endif
        do_reset();
        set_req(1, vec_a(1), vec_b(1), vec_op(1));
        #1;
        tick();
        clear_inputs();
        drain("prio_setup");
        set_req(0, vec_a(0), vec_b(0), vec_op(0));
        set_req(2, vec_a(2), vec_b(2), vec_op(2));
        #1;
        checks++; if (bus.req_ready !== exp_first) begin errors++; $display("FAIL prio_first: got %b required %b", bus.req_ready, exp_first); end
        tick();
        checks++; if (bus.req_ready !== exp_second) begin errors++; $display("FAIL prio_second: got %b required %b", bus.req_ready, exp_second); end
        tick();
        clear_inputs();
        drain("prio");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_pointer_wrap();
        test_outstanding_block();
        test_reset_midflight();
        test_prio();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
